hazard_sequencer: RTL and testbench
===================================

Name: hazard_sequencer

Overview:
- Pipeline controller for the 5-stage core.
- Generates stall, flush and forwarding controls for the F/D/E/M/W stage registers: StallD/FlushD to the decode stage, and the equivalents for the other stages.
- Sequences multi-cycle waits on the instruction memory and data memory ready handshakes.
- Discards a fetch that is still in flight when a taken branch or jump redirects the PC.
- Keeps a stall-cycle performance counter.

Parameters:
- word_width, 32, width of stall_count.
- reg_addr_width, 5, register specifier width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- Rs1D, Rs2D  in  5 each  source registers in D.
- Rs1E, Rs2E, RdE  in  5 each  source and destination registers in E.
- ResultSrcE0  in  1  bit 0 of ResultSrcE; 1 means the instruction in E is a load.
- PCSrcE  in  1  taken branch or jump resolved in E.
- RdM  in  5  destination register in M.
- RegWriteM  in  1  M-stage write enable.
- MemAccessM  in  1  load or store in M.
- RdW  in  5  destination register in W.
- RegWriteW  in  1  W-stage write enable.
- imem_ready  in  1  instruction word valid this cycle.
- dmem_ready  in  1  data access completes this cycle.
- StallF, StallD, StallE, StallM  out  1 each  hold the stage register.
- FlushD, FlushE, FlushW  out  1 each  load a bubble into the stage register.
- ForwardAE, ForwardBE  out  2 each  E-stage operand mux select: 00 = RF, 01 = ResultW, 10 = ALUResultM.
- state  out  2  FSM state, for debug.
- stall_count  out  word_width  count of cycles with StallF=1.

Behaviour:
- FSM states: RUN=00, IWAIT=01, IDROP=10, DWAIT=11. Register updates on posedge clk.
- Reset:
  - While reset=1: state=RUN, stall_count=0, every Stall*/Flush* output forced 0, ForwardAE=ForwardBE=00.
  - Reset asserted mid-wait abandons the wait immediately; no extra FlushD on release.
- Forwarding (combinational, independent of state). ForwardAE:
  - 10 if RegWriteM & RdM!=0 & RdM==Rs1E.
  - else 01 if RegWriteW & RdW!=0 & RdW==Rs1E.
  - else 00.
  - M has priority over W. ForwardBE is the same rule using Rs2E.
- lwStall = ResultSrcE0 & RdE!=0 & (RdE==Rs1D | RdE==Rs2D).
- dwait = MemAccessM & ~dmem_ready. iwait = ~imem_ready.
- Output priority, highest first:
  1. dwait (any state): StallF=StallD=StallE=StallM=1, FlushW=1. No other flush is asserted, including when PCSrcE=1; the redirect is applied once M completes.
  2. PCSrcE=1: FlushD=1, FlushE=1. No stalls.
  3. lwStall: StallF=StallD=1, FlushE=1.
  4. iwait, or state==IDROP with imem_ready=0: StallF=1, FlushD=1 (bubble into D).
  5. state==IDROP & imem_ready=1: FlushD=1, StallF=0. The returning stale word is dropped.
- Transitions:
  - Any state, when dwait: next=DWAIT, except IDROP, which holds IDROP (the drop obligation is preserved).
  - DWAIT -> RUN when dmem_ready=1, or when MemAccessM=0.
  - RUN -> IWAIT when iwait & ~PCSrcE.
  - RUN -> IDROP when iwait & PCSrcE.
  - IWAIT -> RUN on imem_ready=1.
  - IWAIT -> IDROP on PCSrcE=1 while imem_ready=0.
  - IDROP -> RUN on imem_ready=1.
  - Otherwise the state holds.
- If PCSrcE and imem_ready are both 1 in IWAIT, the word is accepted into D and then flushed by the PCSrcE rule; next state is RUN.
- stall_count increments by 1 on every cycle with StallF=1 and wraps modulo 2^word_width. It is not cleared except by reset.
- All control outputs are combinational from state and inputs (zero latency). Only state and stall_count are registered.
- x0 is never a forwarding or hazard source.

Test Plan:
- RdM=5, RegWriteM=1, Rs1E=5, RdW=5, RegWriteW=1 -> ForwardAE=10. With RdM=0 -> ForwardAE=01. With Rs1E=0 -> ForwardAE=00.
- Load in E with RdE=7, Rs2D=7 -> exactly one cycle of StallF=StallD=FlushE=1; stall_count goes 0 -> 1.
- imem_ready low for 3 cycles from RUN -> state IWAIT, 3 cycles of StallF=FlushD=1, then RUN; stall_count=3.
- IWAIT, then PCSrcE=1 while imem_ready=0 -> IDROP. Two more wait cycles, then imem_ready=1 -> FlushD=1, StallF=0 on that cycle, state returns to RUN.
- MemAccessM=1, dmem_ready=0 for 2 cycles, with PCSrcE=1 and lwStall true concurrently -> StallF/D/E/M=1, FlushW=1, FlushD=FlushE=0, state DWAIT. On dmem_ready=1 -> RUN.
- Assert reset during DWAIT -> all Stall*/Flush* outputs immediately 0, state=RUN, stall_count=0.

Source files
------------

// File: rtl/hazard_sequencer.sv
// Pipeline hazard controller for the 5-stage core: forwarding selects, stall/flush
// generation, instruction/data memory wait sequencing and a stall-cycle counter.
module hazard_sequencer #(
  parameter int word_width     = 32,
  parameter int reg_addr_width = 5
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [reg_addr_width-1:0] Rs1D,
  input  logic [reg_addr_width-1:0] Rs2D,
  input  logic [reg_addr_width-1:0] Rs1E,
  input  logic [reg_addr_width-1:0] Rs2E,
  input  logic [reg_addr_width-1:0] RdE,
  input  logic                      ResultSrcE0,
  input  logic                      PCSrcE,
  input  logic [reg_addr_width-1:0] RdM,
  input  logic                      RegWriteM,
  input  logic                      MemAccessM,
  input  logic [reg_addr_width-1:0] RdW,
  input  logic                      RegWriteW,
  input  logic                      imem_ready,
  input  logic                      dmem_ready,
  output logic                      StallF,
  output logic                      StallD,
  output logic                      StallE,
  output logic                      StallM,
  output logic                      FlushD,
  output logic                      FlushE,
  output logic                      FlushW,
  output logic [1:0]                ForwardAE,
  output logic [1:0]                ForwardBE,
  output logic [1:0]                state,
  output logic [word_width-1:0]     stall_count
);

  typedef enum logic [1:0] {
    RUN   = 2'b00,
    IWAIT = 2'b01,
    IDROP = 2'b10,
    DWAIT = 2'b11
  } state_t;

  state_t                state_q, state_d;
  logic [word_width-1:0] count_q;
  logic                  lwStall, dwait, iwait;

  assign lwStall = ResultSrcE0 && (RdE != '0) && ((RdE == Rs1D) || (RdE == Rs2D));
  assign dwait   = MemAccessM && !dmem_ready;
  assign iwait   = !imem_ready;

  // M-stage result wins over W; x0 never forwards.
  always_comb begin
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    if (!reset) begin
      if (RegWriteM && (RdM != '0) && (RdM == Rs1E))
        ForwardAE = 2'b10;
      else if (RegWriteW && (RdW != '0) && (RdW == Rs1E))
        ForwardAE = 2'b01;
      if (RegWriteM && (RdM != '0) && (RdM == Rs2E))
        ForwardBE = 2'b10;
      else if (RegWriteW && (RdW != '0) && (RdW == Rs2E))
        ForwardBE = 2'b01;
    end
  end

  // A pending data access freezes everything, deferring any redirect until M completes.
  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    FlushW = 1'b0;
    if (!reset) begin
      if (dwait) begin
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        StallM = 1'b1;
        FlushW = 1'b1;
      end else if (PCSrcE) begin
        FlushD = 1'b1;
        FlushE = 1'b1;
      end else if (lwStall) begin
        StallF = 1'b1;
        StallD = 1'b1;
        FlushE = 1'b1;
      end else if (iwait) begin
        StallF = 1'b1;
        FlushD = 1'b1;
      end else if (state_q == IDROP) begin
        FlushD = 1'b1;
      end
    end
  end

  // IDROP survives a data wait so the stale fetch is still discarded afterwards.
  always_comb begin
    state_d = state_q;
    if (dwait) begin
      state_d = (state_q == IDROP) ? IDROP : DWAIT;
    end else begin
      case (state_q)
        RUN:   if (iwait) state_d = PCSrcE ? IDROP : IWAIT;
        IWAIT: begin
          if (imem_ready)  state_d = RUN;
          else if (PCSrcE) state_d = IDROP;
        end
        IDROP: if (imem_ready) state_d = RUN;
        DWAIT: state_d = RUN;
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      if (StallF)
        count_q <= count_q + word_width'(1);
    end
  end

  assign state       = state_q;
  assign stall_count = count_q;

endmodule

// File: tb/tb_hazard_sequencer.sv
// Directed self-checking bench for hazard_sequencer: forwarding, load-use stall,
// fetch waits, fetch drop after redirect, data waits and reset during a wait.
module tb_hazard_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic        ResultSrcE0, PCSrcE, RegWriteM, MemAccessM, RegWriteW;
  logic        imem_ready, dmem_ready;
  logic        StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
  logic [1:0]  ForwardAE, ForwardBE, state;
  logic [31:0] stall_count;

  int nChecks = 0;
  int nFails  = 0;
  logic [31:0] expCount = 0;

  localparam logic [1:0] RUN = 2'b00, IWAIT = 2'b01, IDROP = 2'b10, DWAIT = 2'b11;

  hazard_sequencer #(.word_width(32), .reg_addr_width(5)) dut (
    .clk(clk), .reset(reset),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .ResultSrcE0(ResultSrcE0), .PCSrcE(PCSrcE),
    .RdM(RdM), .RegWriteM(RegWriteM), .MemAccessM(MemAccessM),
    .RdW(RdW), .RegWriteW(RegWriteW),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .state(state), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  // Controls packed as {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushW}.
  function automatic logic [6:0] ctl();
    return {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW};
  endfunction

  task automatic setIdle();
    Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
    ResultSrcE0 = 0; PCSrcE = 0; RegWriteM = 0; MemAccessM = 0; RegWriteW = 0;
    imem_ready = 1; dmem_ready = 1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    setIdle();
    reset = 1;
    MemAccessM = 1; dmem_ready = 0; PCSrcE = 1; imem_ready = 0;
    RdM = 5; RegWriteM = 1; Rs1E = 5; Rs2E = 5;
    step(); step();
    @(negedge clk);
    nChecks++; if (ctl() !== 7'b0) begin nFails++; $display("[TB] FAIL reset_ctl: got %b expected %b", ctl(), 7'b0); end
    nChecks++; if (state !== RUN) begin nFails++; $display("[TB] FAIL reset_state: got %b expected %b", state, RUN); end
    nChecks++; if (stall_count !== 32'd0) begin nFails++; $display("[TB] FAIL reset_count: got %0d expected 0", stall_count); end
    nChecks++; if ({ForwardAE, ForwardBE} !== 4'b0) begin nFails++; $display("[TB] FAIL reset_fwd: got %b expected 0000", {ForwardAE, ForwardBE}); end
    setIdle();
    #2 reset = 0;
    step();
  endtask

  task automatic test_forwarding();
    setIdle();
    RdM = 5; RegWriteM = 1; Rs1E = 5; Rs2E = 5; RdW = 5; RegWriteW = 1;
    #1;
    nChecks++; if (ForwardAE !== 2'b10) begin nFails++; $display("[TB] FAIL fwd_m_prio: got %b expected 10", ForwardAE); end
    nChecks++; if (ForwardBE !== 2'b10) begin nFails++; $display("[TB] FAIL fwd_b_m: got %b expected 10", ForwardBE); end
    RdM = 0; #1;
    nChecks++; if (ForwardAE !== 2'b01) begin nFails++; $display("[TB] FAIL fwd_rdm_x0: got %b expected 01", ForwardAE); end
    RdM = 5; RegWriteM = 0; Rs2E = 6; RdW = 6; #1;
    nChecks++; if (ForwardBE !== 2'b01) begin nFails++; $display("[TB] FAIL fwd_b_w: got %b expected 01", ForwardBE); end
    nChecks++; if (ForwardAE !== 2'b00) begin nFails++; $display("[TB] FAIL fwd_a_none: got %b expected 00", ForwardAE); end
    RegWriteM = 1; RdM = 5; RdW = 0; Rs1E = 0; RdM = 0; #1;
    nChecks++; if (ForwardAE !== 2'b00) begin nFails++; $display("[TB] FAIL fwd_rs1e_x0: got %b expected 00", ForwardAE); end
    setIdle();
    step();
  endtask

  task automatic test_load_stall();
    setIdle();
    ResultSrcE0 = 1; RdE = 0; Rs1D = 0;
    @(negedge clk);
    nChecks++; if (ctl() !== 7'b0) begin nFails++; $display("[TB] FAIL lw_x0_ctl: got %b expected %b", ctl(), 7'b0); end
    step();
    RdE = 7; Rs2D = 7; Rs1D = 3;
    @(negedge clk);
    nChecks++; if (ctl() !== 7'b1100010) begin nFails++; $display("[TB] FAIL lw_ctl: got %b expected %b", ctl(), 7'b1100010); end
    nChecks++; if (stall_count !== expCount) begin nFails++; $display("[TB] FAIL lw_count_before: got %0d expected %0d", stall_count, expCount); end
    step(); expCount++;
    setIdle();
    @(negedge clk);
    nChecks++; if (stall_count !== expCount) begin nFails++; $display("[TB] FAIL lw_count_after: got %0d expected %0d", stall_count, expCount); end
    nChecks++; if (ctl() !== 7'b0) begin nFails++; $display("[TB] FAIL lw_release: got %b expected %b", ctl(), 7'b0); end
    step();
  endtask

  task automatic test_imem_wait();
    logic [1:0] expState [3];
    expState[0] = RUN; expState[1] = IWAIT; expState[2] = IWAIT;
    setIdle();
    for (int i = 0; i < 3; i++) begin
      imem_ready = 0;
      @(negedge clk);
      nChecks++; if (ctl() !== 7'b1000100) begin nFails++; $display("[TB] FAIL iwait_ctl[%0d]: got %b expected %b", i, ctl(), 7'b1000100); end
      nChecks++; if (state !== expState[i]) begin nFails++; $display("[TB] FAIL iwait_state[%0d]: got %b expected %b", i, state, expState[i]); end
      step(); expCount++;
    end
    imem_ready = 1;
    @(negedge clk);
    nChecks++; if (ctl() !== 7'b0) begin nFails++; $display("[TB] FAIL iwait_done_ctl: got %b expected %b", ctl(), 7'b0); end
    step();
    nChecks++; if (state !== RUN) begin nFails++; $display("[TB] FAIL iwait_to_run: got %b expected %b", state, RUN); end
    nChecks++; if (stall_count !== expCount) begin nFails++; $display("[TB] FAIL iwait_count: got %0d expected %0d", stall_count, expCount); end
  endtask

  task automatic test_idrop();
    setIdle();
    imem_ready = 0;
    step(); expCount++;
    PCSrcE = 1;
    @(negedge clk);
    nChecks++; if (ctl() !== 7'b0000110) begin nFails++; $display("[TB] FAIL idrop_redirect_ctl: got %b expected %b", ctl(), 7'b0000110); end
    step();
    PCSrcE = 0;
    nChecks++; if (state !== IDROP) begin nFails++; $display("[TB] FAIL idrop_enter: got %b expected %b", state, IDROP); end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      nChecks++; if (ctl() !== 7'b1000100) begin nFails++; $display("[TB] FAIL idrop_wait_ctl[%0d]: got %b expected %b", i, ctl(), 7'b1000100); end
      step(); expCount++;
    end
    imem_ready = 1;
    @(negedge clk);
    nChecks++; if (ctl() !== 7'b0000100) begin nFails++; $display("[TB] FAIL idrop_drop_ctl: got %b expected %b", ctl(), 7'b0000100); end
    nChecks++; if (state !== IDROP) begin nFails++; $display("[TB] FAIL idrop_drop_state: got %b expected %b", state, IDROP); end
    step();
    nChecks++; if (state !== RUN) begin nFails++; $display("[TB] FAIL idrop_to_run: got %b expected %b", state, RUN); end
    nChecks++; if (stall_count !== expCount) begin nFails++; $display("[TB] FAIL idrop_count: got %0d expected %0d", stall_count, expCount); end
  endtask

  task automatic test_iwait_branch_accept();
    setIdle();
    imem_ready = 0;
    step(); expCount++;
    imem_ready = 1; PCSrcE = 1;
    @(negedge clk);
    nChecks++; if (ctl() !== 7'b0000110) begin nFails++; $display("[TB] FAIL iwait_br_ctl: got %b expected %b", ctl(), 7'b0000110); end
    step();
    setIdle();
    nChecks++; if (state !== RUN) begin nFails++; $display("[TB] FAIL iwait_br_state: got %b expected %b", state, RUN); end
  endtask

  task automatic test_dwait();
    logic [1:0] expState [2];
    expState[0] = RUN; expState[1] = DWAIT;
    setIdle();
    MemAccessM = 1; dmem_ready = 0; PCSrcE = 1;
    ResultSrcE0 = 1; RdE = 7; Rs1D = 7;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      nChecks++; if (ctl() !== 7'b1111001) begin nFails++; $display("[TB] FAIL dwait_ctl[%0d]: got %b expected %b", i, ctl(), 7'b1111001); end
      nChecks++; if (state !== expState[i]) begin nFails++; $display("[TB] FAIL dwait_state[%0d]: got %b expected %b", i, state, expState[i]); end
      step(); expCount++;
    end
    dmem_ready = 1;
    @(negedge clk);
    nChecks++; if (ctl() !== 7'b0000110) begin nFails++; $display("[TB] FAIL dwait_release_ctl: got %b expected %b", ctl(), 7'b0000110); end
    step();
    setIdle();
    nChecks++; if (state !== RUN) begin nFails++; $display("[TB] FAIL dwait_to_run: got %b expected %b", state, RUN); end
    nChecks++; if (stall_count !== expCount) begin nFails++; $display("[TB] FAIL dwait_count: got %0d expected %0d", stall_count, expCount); end
  endtask

  task automatic test_dwait_in_idrop();
    setIdle();
    imem_ready = 0; PCSrcE = 1;
    step();
    PCSrcE = 0; MemAccessM = 1; dmem_ready = 0;
    @(negedge clk);
    nChecks++; if (ctl() !== 7'b1111001) begin nFails++; $display("[TB] FAIL idrop_dwait_ctl: got %b expected %b", ctl(), 7'b1111001); end
    step(); expCount++;
    nChecks++; if (state !== IDROP) begin nFails++; $display("[TB] FAIL idrop_dwait_hold: got %b expected %b", state, IDROP); end
    dmem_ready = 1; imem_ready = 1;
    @(negedge clk);
    nChecks++; if (ctl() !== 7'b0000100) begin nFails++; $display("[TB] FAIL idrop_dwait_drop: got %b expected %b", ctl(), 7'b0000100); end
    step();
    setIdle();
    nChecks++; if (state !== RUN) begin nFails++; $display("[TB] FAIL idrop_dwait_run: got %b expected %b", state, RUN); end
    nChecks++; if (stall_count !== expCount) begin nFails++; $display("[TB] FAIL idrop_dwait_count: got %0d expected %0d", stall_count, expCount); end
  endtask

  task automatic test_reset_mid_wait();
    setIdle();
    MemAccessM = 1; dmem_ready = 0;
    step(); expCount++;
    nChecks++; if (state !== DWAIT) begin nFails++; $display("[TB] FAIL rstw_enter: got %b expected %b", state, DWAIT); end
    #2 reset = 1;
    #1;
    nChecks++; if (ctl() !== 7'b0) begin nFails++; $display("[TB] FAIL rstw_ctl: got %b expected %b", ctl(), 7'b0); end
    nChecks++; if (state !== RUN) begin nFails++; $display("[TB] FAIL rstw_state: got %b expected %b", state, RUN); end
    nChecks++; if (stall_count !== 32'd0) begin nFails++; $display("[TB] FAIL rstw_count: got %0d expected 0", stall_count); end
    expCount = 0;
    setIdle();
    step();
    #2 reset = 0;
    @(negedge clk);
    nChecks++; if (ctl() !== 7'b0) begin nFails++; $display("[TB] FAIL rstw_release_ctl: got %b expected %b", ctl(), 7'b0); end
    step();
    nChecks++; if (state !== RUN) begin nFails++; $display("[TB] FAIL rstw_release_state: got %b expected %b", state, RUN); end
  endtask

  initial begin
    setIdle();
    reset = 1;
    test_reset();
    test_forwarding();
    test_load_stall();
    test_imem_wait();
    test_idrop();
    test_iwait_branch_accept();
    test_dwait();
    test_dwait_in_idrop();
    test_reset_mid_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
